// File: rtl/euler_pkg.sv
// Shared types and constants for the Euler spring-chain integrator.
package euler_pkg;

  localparam int FRAC_BITS = 16;

  typedef enum logic [1:0] {IDLE, MUL, UPD, EMIT} state_e;

  // Two's-complement saturation bounds for a w-bit signed word.
  function automatic longint sat_max(int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/euler_chain_integrator_if.sv
// Control, coefficient/init load and sample-stream bundle of the integrator.
interface euler_chain_integrator_if #(
  parameter int WIDTH = 18
);
  logic             k_wr_en;
  logic [3:0]       k_wr_idx;
  logic [WIDTH-1:0] k_wr_data;
  logic             init_wr_en;
  logic [2:0]       init_idx;
  logic [WIDTH-1:0] init_x;
  logic [WIDTH-1:0] init_v;
  logic             load;
  logic             step;
  logic             busy;
  logic             done;
  logic             sample_valid;
  logic             sample_ready;
  logic [2:0]       sample_idx;
  logic [WIDTH-1:0] sample_x;
  logic [WIDTH-1:0] sample_v;

  modport master (
    output k_wr_en, k_wr_idx, k_wr_data, init_wr_en, init_idx, init_x, init_v,
           load, step, sample_ready,
    input  busy, done, sample_valid, sample_idx, sample_x, sample_v
  );

  modport slave (
    input  k_wr_en, k_wr_idx, k_wr_data, init_wr_en, init_idx, init_x, init_v,
           load, step, sample_ready,
    output busy, done, sample_valid, sample_idx, sample_x, sample_v
  );
endinterface

// File: rtl/sat_fx_mul.sv
// Signed fixed-point multiply: full product, keep [WIDTH+15:16], saturate.
module sat_fx_mul
  import euler_pkg::*;
#(
  parameter int WIDTH = 18
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] p
);
  localparam logic signed [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH));
  localparam logic signed [WIDTH-1:0] SMIN = WIDTH'(sat_min(WIDTH));

  logic signed [2*WIDTH-1:0]  full;
  logic [WIDTH-FRAC_BITS:0]   hi;
  logic                       unused_frac;

  // The kept field fits only when every bit above it matches its sign bit.
  always_comb begin
    full = a * b;
    hi   = full[2*WIDTH-1:WIDTH+FRAC_BITS-1];
    if ((&hi) || !(|hi)) p = full[WIDTH+FRAC_BITS-1:FRAC_BITS];
    else                 p = full[2*WIDTH-1] ? SMIN : SMAX;
  end

  assign unused_frac = ^full[FRAC_BITS-1:0];
endmodule

// File: rtl/euler_chain_integrator.sv
// Explicit-Euler integrator for a wall-anchored spring chain, one shared
// multiplier: MUL (2 products/mass) -> UPD (1 mass/cycle) -> EMIT stream.
module euler_chain_integrator
  import euler_pkg::*;
#(
  parameter int N_MASS   = 2,
  parameter int WIDTH    = 18,
  parameter int DT_SHIFT = 8
) (
  input  logic clk,
  input  logic reset_n,
  euler_chain_integrator_if.slave bus
);
  typedef logic signed [WIDTH-1:0] word_t;

  localparam word_t SMAX = WIDTH'(sat_max(WIDTH));
  localparam word_t SMIN = WIDTH'(sat_min(WIDTH));

  function automatic word_t sat1(input logic signed [WIDTH:0] s);
    word_t r;
    if (s[WIDTH] != s[WIDTH-1]) r = s[WIDTH] ? SMIN : SMAX;
    else                        r = s[WIDTH-1:0];
    return r;
  endfunction

  function automatic word_t add_sat(input word_t a, input word_t b);
    return sat1({a[WIDTH-1], a} + {b[WIDTH-1], b});
  endfunction

  function automatic word_t sub_sat(input word_t a, input word_t b);
    return sat1({a[WIDTH-1], a} - {b[WIDTH-1], b});
  endfunction

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  word_t      acc_q, acc_d;
  logic       done_q, done_d;
  word_t      k_q     [N_MASS+1];
  word_t      k_d     [N_MASS+1];
  word_t      ix_q    [N_MASS];
  word_t      ix_d    [N_MASS];
  word_t      iv_q    [N_MASS];
  word_t      iv_d    [N_MASS];
  word_t      x_q     [N_MASS];
  word_t      x_d     [N_MASS];
  word_t      v_q     [N_MASS];
  word_t      v_d     [N_MASS];
  word_t      accel_q [N_MASS];
  word_t      accel_d [N_MASS];

  int    mi;
  word_t x_l, x_c, x_r, v_c, a_c, k_l, k_r;
  word_t mul_a, mul_b, prod;

  // Operand fetch for the mass in focus; neighbours past either end are walls at 0.
  always_comb begin
    mi  = (state_q == MUL) ? int'(cnt_q >> 1) : int'(cnt_q);
    x_l = '0;
    x_c = '0;
    x_r = '0;
    v_c = '0;
    a_c = '0;
    k_l = '0;
    k_r = '0;
    for (int j = 0; j < N_MASS; j++) begin
      if (j == mi - 1) x_l = x_q[j];
      if (j == mi + 1) x_r = x_q[j];
      if (j == mi) begin
        x_c = x_q[j];
        v_c = v_q[j];
        a_c = accel_q[j];
      end
    end
    for (int j = 0; j <= N_MASS; j++) begin
      if (j == mi)     k_l = k_q[j];
      if (j == mi + 1) k_r = k_q[j];
    end
    mul_a = cnt_q[0] ? k_r : k_l;
    mul_b = cnt_q[0] ? sub_sat(x_r, x_c) : sub_sat(x_l, x_c);
  end

  sat_fx_mul #(.WIDTH(WIDTH)) u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (prod)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    k_d     = k_q;
    ix_d    = ix_q;
    iv_d    = iv_q;
    x_d     = x_q;
    v_d     = v_q;
    accel_d = accel_q;

    if (bus.init_wr_en) begin
      for (int j = 0; j < N_MASS; j++) begin
        if (int'(bus.init_idx) == j) begin
          ix_d[j] = bus.init_x;
          iv_d[j] = bus.init_v;
        end
      end
    end

    if (bus.k_wr_en && state_q == IDLE) begin
      for (int j = 0; j <= N_MASS; j++) begin
        if (int'(bus.k_wr_idx) == j) k_d[j] = bus.k_wr_data;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.step) begin
          state_d = MUL;
          cnt_d   = '0;
        end
      end
      MUL: begin
        // Even cycle holds the left-spring term; odd cycle adds the right one.
        if (!cnt_q[0]) acc_d = prod;
        else begin
          for (int j = 0; j < N_MASS; j++) begin
            if (j == mi) accel_d[j] = add_sat(acc_q, prod);
          end
        end
        if (cnt_q == 5'(2 * N_MASS - 1)) begin
          state_d = UPD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      UPD: begin
        for (int j = 0; j < N_MASS; j++) begin
          if (j == mi) begin
            x_d[j] = add_sat(x_c, v_c >>> DT_SHIFT);
            v_d[j] = add_sat(v_c, a_c >>> DT_SHIFT);
          end
        end
        if (cnt_q == 5'(N_MASS - 1)) begin
          state_d = EMIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      EMIT: begin
        if (bus.sample_ready) begin
          if (cnt_q == 5'(N_MASS - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Load beats everything: it also drops a pending step or aborts a running one.
    if (bus.load) begin
      x_d     = ix_q;
      v_d     = iv_q;
      state_d = IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
      for (int j = 0; j <= N_MASS; j++) k_q[j] <= '0;
      for (int j = 0; j < N_MASS; j++) begin
        ix_q[j]    <= '0;
        iv_q[j]    <= '0;
        x_q[j]     <= '0;
        v_q[j]     <= '0;
        accel_q[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
      k_q     <= k_d;
      ix_q    <= ix_d;
      iv_q    <= iv_d;
      x_q     <= x_d;
      v_q     <= v_d;
      accel_q <= accel_d;
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = done_q;
  assign bus.sample_valid = (state_q == EMIT);
  assign bus.sample_idx   = (state_q == EMIT) ? cnt_q[2:0] : 3'd0;
  assign bus.sample_x     = (state_q == EMIT) ? x_c : '0;
  assign bus.sample_v     = (state_q == EMIT) ? v_c : '0;
endmodule

// File: tb/tb_euler_chain_integrator.sv
// Directed scoreboard bench: stimulus pushes expected samples, a monitor pops/compares.
module tb_euler_chain_integrator;
  localparam int W = 18;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  euler_chain_integrator_if #(.WIDTH(W)) bus ();

  euler_chain_integrator #(.N_MASS(2), .WIDTH(W), .DT_SHIFT(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [2:0]   idx;
    logic [W-1:0] x;
    logic [W-1:0] v;
  } samp_t;

  samp_t exp_q[$];
  int    n_tests  = 0;
  int    n_fail   = 0;
  int    done_cnt = 0;
  logic  stall_prev = 1'b0;
  samp_t held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts done pulses, checks hold-under-stall, scores each handshake.
  always @(negedge clk) begin
    samp_t cur;
    samp_t e;
    if (reset_n === 1'b1) begin
      cur = {bus.sample_idx, bus.sample_x, bus.sample_v};
      if (bus.done === 1'b1) done_cnt++;
      if (stall_prev) begin
        chk("stall_valid_held", 64'(bus.sample_valid), 64'd1);
        chk("stall_data_held", 64'(cur), 64'(held));
      end
      if (bus.sample_valid === 1'b1 && bus.sample_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_sample: got %h expected none", cur);
        end else begin
          e = exp_q.pop_front();
          chk("sample", 64'(cur), 64'(e));
        end
      end
      stall_prev = (bus.sample_valid === 1'b1) && (bus.sample_ready === 1'b0);
      held = cur;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_k(input int i, input logic [W-1:0] d);
    bus.k_wr_en   = 1'b1;
    bus.k_wr_idx  = 4'(i);
    bus.k_wr_data = d;
    tick();
    bus.k_wr_en   = 1'b0;
  endtask

  task automatic wr_init(input int i, input logic [W-1:0] x, input logic [W-1:0] v);
    bus.init_wr_en = 1'b1;
    bus.init_idx   = 3'(i);
    bus.init_x     = x;
    bus.init_v     = v;
    tick();
    bus.init_wr_en = 1'b0;
  endtask

  task automatic do_load();
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  task automatic push(input int i, input logic [W-1:0] x, input logic [W-1:0] v);
    samp_t s;
    s.idx = 3'(i);
    s.x   = x;
    s.v   = v;
    exp_q.push_back(s);
  endtask

  // Leaves the bench in cycle 1 after the step edge.
  task automatic do_step();
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int c = 0;
    while (bus.sample_valid !== 1'b1 && c < 64) begin
      tick();
      c++;
    end
    chk(name, 64'(bus.sample_valid), 64'd1);
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while (bus.busy !== 1'b0 && c < 200) begin
      tick();
      c++;
    end
    chk({name, "_idle"}, 64'(bus.busy), 64'd0);
    chk({name, "_done"}, 64'(bus.done), 64'd1);
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int d0;
    bus.k_wr_en = 0; bus.k_wr_idx = 0; bus.k_wr_data = 0;
    bus.init_wr_en = 0; bus.init_idx = 0; bus.init_x = 0; bus.init_v = 0;
    bus.sample_ready = 1'b1;

    // Reset with load and step asserted: reset must win.
    reset_n  = 1'b0;
    bus.load = 1'b1;
    bus.step = 1'b1;
    tick();
    tick();
    chk("reset_outputs", 64'({bus.busy, bus.done, bus.sample_valid, bus.sample_idx,
                              bus.sample_x, bus.sample_v}), 64'd0);
    bus.load = 1'b0;
    bus.step = 1'b0;
    reset_n  = 1'b1;
    tick();
    chk("post_reset_busy", 64'(bus.busy), 64'd0);

    // Basic step: k = 1.0, x = (-0.5, 0.5), v = 0.
    wr_k(0, 18'h10000);
    wr_k(1, 18'h10000);
    wr_k(2, 18'h10000);
    wr_init(0, 18'h38000, 18'h0);
    wr_init(1, 18'h08000, 18'h0);
    do_load();
    push(0, 18'h38000, 18'h00180);
    push(1, 18'h08000, 18'h3FE80);
    do_step();
    chk("busy_cycle1", 64'(bus.busy), 64'd1);
    cyc = 1;
    while (bus.sample_valid !== 1'b1 && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("first_valid_cycle", 64'(cyc), 64'd7);
    wait_idle("step1");

    // Second step; a k write while busy and a step during EMIT are both ignored.
    // x[1] update: -0x180 >>> 8 floors to -2.
    push(0, 18'h38001, 18'h00300);
    push(1, 18'h07FFE, 18'h3FD00);
    do_step();
    bus.k_wr_en = 1'b1; bus.k_wr_idx = 4'd1; bus.k_wr_data = 18'h0;
    tick();
    bus.k_wr_en = 1'b0;
    wait_valid("step2_valid");
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    wait_idle("step2");
    chk("step_in_emit_ignored", 64'(bus.busy), 64'd0);

    // Third step with a 5-cycle stall on sample 0.
    push(0, 18'h38004, 18'h0047F);
    push(1, 18'h07FFB, 18'h3FB80);
    bus.sample_ready = 1'b0;
    d0 = done_cnt;
    do_step();
    wait_valid("step3_valid");
    repeat (5) tick();
    chk("stall_idx0", 64'(bus.sample_idx), 64'd0);
    chk("stall_no_done", 64'(done_cnt), 64'(d0));
    bus.sample_ready = 1'b1;
    wait_idle("step3");
    chk("stall_done_once", 64'(done_cnt), 64'(d0 + 1));

    // Abort: load at MUL cycle 2 restores init state; no done, no samples.
    do_load();
    do_step();
    tick();
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_valid", 64'(bus.sample_valid), 64'd0);
    d0 = done_cnt;
    repeat (10) tick();
    chk("abort_no_done", 64'(done_cnt), 64'(d0));
    push(0, 18'h38000, 18'h00180);
    push(1, 18'h08000, 18'h3FE80);
    do_step();
    wait_idle("after_abort");

    // Load and step together: load wins. Out-of-range writes must not alias.
    wr_init(0, 18'h10000, 18'h0);
    wr_init(1, 18'h00000, 18'h0);
    wr_init(2, 18'h12345, 18'h12345);
    wr_init(7, 18'h2ABCD, 18'h2ABCD);
    wr_k(3, 18'h0);
    wr_k(15, 18'h0);
    bus.load = 1'b1;
    bus.step = 1'b1;
    tick();
    bus.load = 1'b0;
    bus.step = 1'b0;
    chk("load_step_busy", 64'(bus.busy), 64'd0);
    repeat (4) tick();
    chk("load_step_still_idle", 64'(bus.busy), 64'd0);
    push(0, 18'h10000, 18'h3FE00);
    push(1, 18'h00000, 18'h00100);
    do_step();
    wait_idle("after_load_step");

    // Saturation: extreme k and x, first with v = 0, then with extreme v.
    wr_k(0, 18'h1FFFF);
    wr_k(1, 18'h1FFFF);
    wr_k(2, 18'h1FFFF);
    wr_init(0, 18'h1FFFF, 18'h0);
    wr_init(1, 18'h20000, 18'h0);
    do_load();
    push(0, 18'h1FFFF, 18'h3FE00);
    push(1, 18'h20000, 18'h001FF);
    do_step();
    wait_idle("sat1");
    wr_init(0, 18'h1FFFF, 18'h1FFFF);
    wr_init(1, 18'h20000, 18'h20000);
    do_load();
    push(0, 18'h1FFFF, 18'h1FDFF);
    push(1, 18'h20000, 18'h201FF);
    do_step();
    wait_idle("sat2");

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
